ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Next-generation keyboard receiver that runs entirely on the system clock and oversamples the PS/2 clock and data lines instead of clocking logic from the keyboard clock. Each frame (start, DATA_W data bits LSB first, parity, stop) is deframed, checked for parity, stop bit and timeout, then pushed into a show-ahead FIFO. The consumer pops bytes with a valid/ready handshake. It sits between the PS/2 pins and the scan-code decoder.

Parameters:
DATA_W, 8, data bits per frame.
ODD_PARITY, 1, 1 = odd parity (PS/2 standard), 0 = even parity.
FILTER_LEN, 4, consecutive identical samples required before the filtered ps2_clk changes level (min 1).
TIMEOUT_CYCLES, 5000, idle clk cycles inside a frame before the frame is aborted.
FIFO_DEPTH, 8, byte FIFO entries (power of 2, >=2).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
ps2_clk  in  1  raw keyboard clock (asynchronous)
ps2_data  in  1  raw keyboard data (asynchronous)
rd  in  1  consumer pop request (ready)
err_clr  in  1  clears sticky overflow
kb_reader_out  out  DATA_W  FIFO head byte; 0 when empty
avail  out  1  FIFO not empty (valid)
fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
parity_err  out  1  one-cycle pulse on a parity failure
frame_err  out  1  one-cycle pulse on a bad stop bit or timeout
overflow  out  1  sticky, set when a good frame is dropped because the FIFO is full

Behaviour:
- Reset: FSM=IDLE, FIFO empty, fill=0, avail=0, kb_reader_out=0, all error outputs 0, filtered clock=1, synchroniser flops=1.
- Input path: 2-FF synchroniser on each line. The filter counts consecutive synchronised ps2_clk samples that differ from the filtered level. When the count reaches FILTER_LEN, the filtered level flips and the counter clears. Any matching sample clears the counter.
- fall = one-cycle strobe on a filtered 1->0 transition. Synchronised ps2_data is sampled on the fall cycle.
- FSM:
  IDLE: on fall with data=0, go to DATA and set bit_cnt=0. On fall with data=1, stay in IDLE with no error.
  DATA: on each fall, shift the bit into shreg LSB-first and increment bit_cnt. After DATA_W bits, go to PARITY.
  PARITY: on fall, par_ok = (^shreg ^ data) == ODD_PARITY. Go to STOP.
  STOP: on fall, go to IDLE. If data=0, pulse frame_err. Else if !par_ok, pulse parity_err. Else push shreg.
- Timeout: in any state other than IDLE, a counter increments every cycle and clears on fall. When it reaches TIMEOUT_CYCLES-1 without a fall, the FSM goes to IDLE and frame_err pulses; the partial frame is discarded.
- FIFO: show-ahead, so kb_reader_out = mem[rd_ptr] whenever avail=1.
  - A pop occurs when rd && avail. rd while empty is ignored.
  - A push on the STOP fall cycle appears at the outputs on the next cycle (avail, fill update). Latency from the stop-bit fall strobe to avail is 1 clk.
  - Push and pop in the same cycle: both happen and fill is unchanged, including when full.
  - Push while full with no pop: the byte is dropped and overflow sets.
- Pointers wrap modulo FIFO_DEPTH. fill saturates exactly at FIFO_DEPTH.
- overflow clears on err_clr or reset. If err_clr and a new overflow occur in the same cycle, set wins.
- Reset mid-frame: the frame is discarded and FIFO contents are lost. The next frame must start from a clean start bit.

Test Plan:
- Send frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> avail=1 one clk after the stop fall, kb_reader_out=0x1C, fill=1. Pulse rd -> avail=0, kb_reader_out=0.
- Send 0x1C with parity bit 1 -> parity_err pulses for 1 cycle, avail stays 0. Send 0x1C with stop bit 0 -> frame_err pulses, FIFO unchanged.
- FIFO_DEPTH=4: send 0x01..0x05 with rd=0 -> fill=4, overflow=1, pops return 0x01,0x02,0x03,0x04. Pulse err_clr -> overflow=0.
- FIFO full, then hold rd=1 while 0x06 arrives -> pop and push in the same cycle, fill stays 4, no overflow, 0x06 read out last.
- Send start plus 3 data bits, then idle the lines -> frame_err after TIMEOUT_CYCLES, FSM in IDLE. Then send 0xF0 -> received correctly.
- Inject ps2_clk low glitches of FILTER_LEN-1 cycles during a 0xAA frame -> no extra bits sampled, 0xAA received. Assert reset mid-frame -> all outputs at reset values, next frame 0x5A received cleanly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver on the system clock: oversampled, glitch-filtered clock,
// frame deframing with parity/stop/timeout checks, feeding a show-ahead byte FIFO.
module ps2_rx_fifo #(
  parameter int DATA_W         = 8,
  parameter int ODD_PARITY     = 1,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd,
  input  logic                          err_clr,
  output logic [DATA_W-1:0]             kb_reader_out,
  output logic                          avail,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FW  = AW + 1;
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW  = $clog2(DATA_W + 1);
  localparam logic ODD_BIT = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Two-flop synchronisers; bit 0 is ps2_clk, bit 1 is ps2_data. Idle bus level is 1.
  logic [1:0] raw_in;
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;
  assign raw_in = {ps2_data, ps2_clk};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg[gi] <= 1'b1;
          sync2_reg[gi] <= 1'b1;
        end else begin
          sync1_reg[gi] <= raw_in[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  logic clk_s;
  logic dat_s;
  assign clk_s = sync2_reg[0];
  assign dat_s = sync2_reg[1];

  logic [FCW-1:0] flt_cnt_reg;
  logic           flt_reg;
  logic           differ;
  logic           flip;
  logic           fall;

  assign differ = clk_s ^ flt_reg;
  assign flip   = differ && (flt_cnt_reg == FCW'(FILTER_LEN - 1));
  assign fall   = flip && flt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      flt_reg     <= 1'b1;
      flt_cnt_reg <= '0;
    end else if (flip) begin
      flt_reg     <= ~flt_reg;
      flt_cnt_reg <= '0;
    end else if (differ) begin
      flt_cnt_reg <= flt_cnt_reg + FCW'(1);
    end else begin
      flt_cnt_reg <= '0;
    end
  end

  state_t            state_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic              par_ok_reg;
  logic [TW-1:0]     tcnt_reg;
  logic              parity_err_reg;
  logic              frame_err_reg;
  logic              timeout;
  logic              push_req;

  assign timeout  = (state_reg != IDLE) && !fall && (tcnt_reg == TW'(TIMEOUT_CYCLES - 1));
  assign push_req = (state_reg == STOP) && fall && dat_s && par_ok_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      bit_cnt_reg    <= '0;
      par_ok_reg     <= 1'b0;
      tcnt_reg       <= '0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (state_reg == IDLE || fall) tcnt_reg <= '0;
      else                           tcnt_reg <= tcnt_reg + TW'(1);

      if (timeout) begin
        state_reg     <= IDLE;
        frame_err_reg <= 1'b1;
      end else if (fall) begin
        case (state_reg)
          IDLE: begin
            if (!dat_s) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            shreg_reg   <= {dat_s, shreg_reg[DATA_W-1:1]};
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
            if (bit_cnt_reg == BW'(DATA_W - 1)) state_reg <= PARITY;
          end
          PARITY: begin
            par_ok_reg <= ((^shreg_reg) ^ dat_s) == ODD_BIT;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            if (!dat_s)           frame_err_reg  <= 1'b1;
            else if (!par_ok_reg) parity_err_reg <= 1'b1;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Show-ahead FIFO: the head entry is presented combinationally while non-empty.
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [FW-1:0]     fill_reg;
  logic              overflow_reg;
  logic              full;
  logic              pop;
  logic              do_push;
  logic              drop;

  assign full    = (fill_reg == FW'(FIFO_DEPTH));
  assign avail   = (fill_reg != '0);
  assign pop     = rd && avail;
  assign do_push = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= shreg_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, pop})
        2'b10:   fill_reg <= fill_reg + FW'(1);
        2'b01:   fill_reg <= fill_reg - FW'(1);
        default: fill_reg <= fill_reg;
      endcase
      if (drop)         overflow_reg <= 1'b1;
      else if (err_clr) overflow_reg <= 1'b0;
    end
  end

  assign kb_reader_out = avail ? mem[rd_ptr_reg] : '0;
  assign fill          = fill_reg;
  assign parity_err    = parity_err_reg;
  assign frame_err     = frame_err_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames with hand-computed results.
module tb_ps2_rx_fifo;

  localparam int FD = 4;
  localparam int TO = 300;
  localparam int FL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] kb;
  logic       avail;
  logic [2:0] fill;
  logic       perr;
  logic       ferr;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  logic obs_avail_pre, obs_avail, obs_perr_pre, obs_ferr_pre;
  logic obs_perr, obs_ferr, obs_perr_after, obs_ferr_after;

  ps2_rx_fifo #(
    .DATA_W(8), .ODD_PARITY(1), .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd(rd), .err_clr(err_clr), .kb_reader_out(kb), .avail(avail),
    .fill(fill), .parity_err(perr), .frame_err(ferr), .overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data set up, clock low 20 cycles, clock high 20 cycles.
  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(20);
    ps2_clk = 1'b1;
    if (glitch) begin
      tick(5);
      ps2_clk = 1'b0;
      tick(FL - 1);
      ps2_clk = 1'b1;
      tick(20 - 5 - (FL - 1));
    end else begin
      tick(20);
    end
  endtask

  task automatic send_head(input logic [7:0] v, input logic par_flip, input logic glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(v[i], glitch);
    send_bit((~^v) ^ par_flip, glitch);
  endtask

  // Stop bit; the filtered fall lands 2 sync + FL filter edges after ps2_clk drops.
  task automatic send_stop(input logic s, input logic pop_at_fall);
    ps2_data = s;
    tick(10);
    ps2_clk = 1'b0;
    tick(5);
    obs_avail_pre = avail;
    obs_perr_pre  = perr;
    obs_ferr_pre  = ferr;
    if (pop_at_fall) rd = 1'b1;
    tick(1);
    rd = 1'b0;
    obs_avail = avail;
    obs_perr  = perr;
    obs_ferr  = ferr;
    tick(1);
    obs_perr_after = perr;
    obs_ferr_after = ferr;
    tick(13);
    ps2_clk = 1'b1;
    tick(20);
    $display("frame done: stop=%b avail=%b fill=%0d head=%h perr=%b ferr=%b ovf=%b",
             s, avail, fill, kb, obs_perr, obs_ferr, ovf);
  endtask

  task automatic send_frame(input logic [7:0] v);
    send_head(v, 1'b0, 1'b0);
    send_stop(1'b1, 1'b0);
  endtask

  task automatic pop_one();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL reset_avail got %b want 0", avail); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill); end
    checks++; if (kb !== 8'h00) begin errors++; $display("FAIL reset_kb got %h want 00", kb); end
    checks++; if ({perr, ferr, ovf} !== 3'b000) begin errors++; $display("FAIL reset_errs got %b want 000", {perr, ferr, ovf}); end
  endtask

  task automatic test_basic();
    send_head(8'h1C, 1'b0, 1'b0);
    send_stop(1'b1, 1'b0);
    checks++; if (obs_avail_pre !== 1'b0) begin errors++; $display("FAIL basic_avail_early got %b want 0", obs_avail_pre); end
    checks++; if (obs_avail !== 1'b1) begin errors++; $display("FAIL basic_avail_latency got %b want 1", obs_avail); end
    checks++; if (kb !== 8'h1C) begin errors++; $display("FAIL basic_data got %h want 1c", kb); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL basic_fill got %0d want 1", fill); end
    checks++; if ({obs_perr, obs_ferr} !== 2'b00) begin errors++; $display("FAIL basic_errs got %b want 00", {obs_perr, obs_ferr}); end
    pop_one();
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL basic_pop_avail got %b want 0", avail); end
    checks++; if (kb !== 8'h00) begin errors++; $display("FAIL basic_pop_kb got %h want 00", kb); end
  endtask

  task automatic test_parity_err();
    send_head(8'h1C, 1'b1, 1'b0);
    send_stop(1'b1, 1'b0);
    checks++; if (obs_perr_pre !== 1'b0) begin errors++; $display("FAIL perr_early got %b want 0", obs_perr_pre); end
    checks++; if (obs_perr !== 1'b1) begin errors++; $display("FAIL perr_pulse got %b want 1", obs_perr); end
    checks++; if (obs_perr_after !== 1'b0) begin errors++; $display("FAIL perr_width got %b want 0", obs_perr_after); end
    checks++; if (obs_ferr !== 1'b0) begin errors++; $display("FAIL perr_no_ferr got %b want 0", obs_ferr); end
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL perr_avail got %b want 0", avail); end
  endtask

  task automatic test_stop_err();
    send_head(8'h1C, 1'b0, 1'b0);
    send_stop(1'b0, 1'b0);
    checks++; if (obs_ferr !== 1'b1) begin errors++; $display("FAIL stop_ferr got %b want 1", obs_ferr); end
    checks++; if (obs_ferr_after !== 1'b0) begin errors++; $display("FAIL stop_ferr_width got %b want 0", obs_ferr_after); end
    checks++; if (obs_perr !== 1'b0) begin errors++; $display("FAIL stop_no_perr got %b want 0", obs_perr); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL stop_fill got %0d want 0", fill); end
    ps2_data = 1'b1;
  endtask

  task automatic test_overflow();
    logic [7:0] e;
    for (int i = 1; i <= 4; i++) send_frame(8'(i));
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL ovf_fill4 got %0d want 4", fill); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ovf); end
    send_frame(8'h05);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL ovf_fill_sat got %0d want 4", fill); end
    for (int i = 1; i <= 4; i++) begin
      e = 8'(i);
      checks++; if (kb !== e) begin errors++; $display("FAIL ovf_pop%0d got %h want %h", i, kb, e); end
      pop_one();
    end
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", avail); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", ovf); end
  endtask

  task automatic test_full_rdwr();
    logic [7:0] exp_q [4];
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
    for (int i = 1; i <= 4; i++) send_frame(8'(i));
    send_head(8'h06, 1'b0, 1'b0);
    send_stop(1'b1, 1'b1);
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL rdwr_fill got %0d want 4", fill); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rdwr_ovf got %b want 0", ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (kb !== exp_q[i]) begin errors++; $display("FAIL rdwr_pop%0d got %h want %h", i, kb, exp_q[i]); end
      pop_one();
    end
  endtask

  task automatic test_timeout();
    int first;
    first = -1;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    // 34 cycles have already elapsed since the last filtered fall.
    for (int k = 1; k <= 2 * TO && first < 0; k++) begin
      tick(1);
      if (ferr) first = k;
    end
    checks++; if (first != TO - 34) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", first, TO - 34); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL timeout_fill got %0d want 0", fill); end
    tick(5);
    send_frame(8'hF0);
    checks++; if (kb !== 8'hF0) begin errors++; $display("FAIL timeout_next got %h want f0", kb); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL timeout_next_fill got %0d want 1", fill); end
    pop_one();
  endtask

  task automatic test_glitch();
    send_head(8'hAA, 1'b0, 1'b1);
    send_stop(1'b1, 1'b0);
    checks++; if (kb !== 8'hAA) begin errors++; $display("FAIL glitch_data got %h want aa", kb); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL glitch_fill got %0d want 1", fill); end
    checks++; if ({obs_perr, obs_ferr} !== 2'b00) begin errors++; $display("FAIL glitch_errs got %b want 00", {obs_perr, obs_ferr}); end
    pop_one();
  endtask

  task automatic test_reset_mid();
    send_frame(8'h33);
    checks++; if (avail !== 1'b1) begin errors++; $display("FAIL rmid_pre_avail got %b want 1", avail); end
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (avail !== 1'b0) begin errors++; $display("FAIL rmid_avail got %b want 0", avail); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rmid_fill got %0d want 0", fill); end
    checks++; if (kb !== 8'h00) begin errors++; $display("FAIL rmid_kb got %h want 00", kb); end
    tick(5);
    send_frame(8'h5A);
    checks++; if (kb !== 8'h5A) begin errors++; $display("FAIL rmid_next got %h want 5a", kb); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL rmid_next_fill got %0d want 1", fill); end
    checks++; if ({obs_perr, obs_ferr} !== 2'b00) begin errors++; $display("FAIL rmid_errs got %b want 00", {obs_perr, obs_ferr}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_stop_err();
    test_overflow();
    test_full_rdwr();
    test_timeout();
    test_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
